apb_mem: RTL and testbench

APB_MEM -- requirements
Module: apb_mem

---
 rtl/apb_mem.sv | 134 +++++++++++++
 tb/tb_apb_mem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem.sv
// APB-style word-addressed memory with byte-lane writes, address error responses and a wait-state FSM.
// Build option: define APB_MEM_WAIT_EN to insert WAIT_CYCLES wait states; otherwise every transfer is zero-wait.
module apb_mem #(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rts,
   input  logic [31:0]           APB_paddr,
   input  logic [DATA_WIDTH-1:0] APB_pdata,
   output logic [DATA_WIDTH-1:0] APB_prdata,
   input  logic                  APB_psel,
   input  logic                  APB_penable,
   input  logic                  APB_pwrite,
   input  logic [3:0]            APB_pstb,
   output logic                  APB_pready,
   output logic                  APB_perr
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

   if (DATA_WIDTH != 32 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_config
      $error("apb_mem: unsupported DATA_WIDTH or WAIT_CYCLES");
   end

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
   logic [AW-1:0]           idx_q;
   logic [DATA_WIDTH-1:0]   pdata_q;
   logic [DATA_WIDTH-1:0]   prdata_q;
   logic                    pwrite_q;
   logic [3:0]              pstb_q;
   logic                    err_q;
`ifdef APB_MEM_WAIT_EN
   logic [3:0]              cnt;
`endif

   // Subtracting the base first makes addresses below BASE_ADDR wrap to huge offsets,
   // so a single unsigned compare catches both range violations.
   logic [31:0]   offset;
   logic          addr_err;
   logic [AW-1:0] req_idx;
   logic          access;
   logic          complete;
   logic          do_write;

   assign offset   = APB_paddr - BASE_ADDR;
   assign addr_err = (offset >= SPAN) || (APB_paddr[1:0] != 2'b00);
   assign req_idx  = offset[AW+1:2];
   assign access   = APB_psel & APB_penable;
   assign complete = (state == RESP) & access & ~rts;
   assign do_write = complete & pwrite_q & ~err_q;

   // Memory array has no reset; only the completion edge of an error-free write touches it.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (pstb_q[i]) begin
               mem[idx_q][8*i +: 8] <= pdata_q[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rts) begin
         state    <= IDLE;
         prdata_q <= '0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         pdata_q  <= '0;
         pwrite_q <= 1'b0;
         pstb_q   <= 4'b0000;
`ifdef APB_MEM_WAIT_EN
         cnt      <= 4'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (APB_psel) begin
                  idx_q    <= req_idx;
                  pdata_q  <= APB_pdata;
                  pwrite_q <= APB_pwrite;
                  pstb_q   <= APB_pstb;
                  err_q    <= addr_err;
                  prdata_q <= addr_err ? '0 : mem[req_idx];
`ifdef APB_MEM_WAIT_EN
                  cnt      <= 4'(WAIT_CYCLES);
                  state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
`else
                  state    <= RESP;
`endif
               end
            end
            WAIT: begin
`ifdef APB_MEM_WAIT_EN
               if (!APB_psel) begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end else if (APB_penable) begin
                  cnt <= cnt - 4'd1;
                  if (cnt <= 4'd1) begin
                     state <= RESP;
                  end
               end
`else
               state <= IDLE;
`endif
            end
            RESP: begin
               // Either the access completes or the initiator abandoned it; both end the transfer.
               if (!APB_psel || APB_penable) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign APB_pready = (state == RESP);
   assign APB_perr   = APB_pready & err_q;
   assign APB_prdata = prdata_q;

endmodule

// File: tb/tb_apb_mem.sv
// Scoreboard bench for apb_mem: the driver queues expected responses, a negedge monitor checks them.
// Expected wait states follow APB_MEM_WAIT_EN (3 when defined, 0 otherwise).
module tb_apb_mem;

   localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef APB_MEM_WAIT_EN
   localparam int EXP_WAITS = 3;
`else
   localparam int EXP_WAITS = 0;
`endif

   logic        clk;
   logic        rts;
   logic [31:0] paddr;
   logic [31:0] pdata;
   logic [31:0] prdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [3:0]  pstb;
   logic        pready;
   logic        perr;

   int checks   = 0;
   int failures = 0;
   int waitCnt  = 0;

   typedef struct {
      bit          checkData;
      logic [31:0] data;
      bit          err;
   } exp_t;

   exp_t expQ[$];

   apb_mem #(
      .DATA_WIDTH (32),
      .BASE_ADDR  (32'h8000_0000),
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES(3)
   ) dut (
      .clk        (clk),
      .rts        (rts),
      .APB_paddr  (paddr),
      .APB_pdata  (pdata),
      .APB_prdata (prdata),
      .APB_psel   (psel),
      .APB_penable(penable),
      .APB_pwrite (pwrite),
      .APB_pstb   (pstb),
      .APB_pready (pready),
      .APB_perr   (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at posedge+1; leaves the bus idle at posedge+1 after the completion edge,
   // so consecutive calls form back-to-back transfers with no idle cycle.
   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                                input logic [3:0] stb, input logic [31:0] expData, input bit expErr,
                                input bit scramble);
      exp_t e;
      bit   done;
      e.checkData = !wr || expErr;
      e.data      = expData;
      e.err       = expErr;
      expQ.push_back(e);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = addr;
      pdata   = data;
      pwrite  = wr;
      pstb    = stb;
      @(posedge clk); #1;
      penable = 1'b1;
      if (scramble) begin
         paddr  = BASE;
         pdata  = 32'h0;
         pstb   = 4'b0000;
         pwrite = ~wr;
      end
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (pready) done = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("[TB] FAIL timeout: addr 0x%08h got no pready expected pready within 40 cycles", addr);
         void'(expQ.pop_back());
      end
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] stb);
      applyStimulus(addr, 1'b1, data, stb, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic doRead(input logic [31:0] addr, input logic [31:0] exp);
      applyStimulus(addr, 1'b0, 32'h0, 4'b0000, exp, 1'b0, 1'b0);
   endtask

   task automatic doError(input logic [31:0] addr, input logic wr);
      applyStimulus(addr, wr, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1, 1'b0);
   endtask

   // Monitor: counts stalled access cycles and pops the scoreboard at each completion.
   always @(negedge clk) begin
      if (rts) begin
         waitCnt = 0;
      end else if (psel && penable) begin
         if (!pready) begin
            waitCnt++;
            checkOutput("perr_without_pready", {31'b0, perr}, 32'h0);
         end else begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_response: got pready=1 expected no transfer");
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("wait_states", waitCnt, EXP_WAITS);
               checkOutput("perr", {31'b0, perr}, {31'b0, e.err});
               if (e.checkData) checkOutput("prdata", prdata, e.data);
            end
            waitCnt = 0;
         end
      end else if (!psel) begin
         waitCnt = 0;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at 200000 ns expected finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rts     = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'h0;
      pdata   = 32'h0;
      pstb    = 4'b0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_pready", {31'b0, pready}, 32'h0);
      checkOutput("reset_perr", {31'b0, perr}, 32'h0);
      checkOutput("reset_prdata", prdata, 32'h0);
      @(posedge clk); #1;
      rts = 1'b0;
      @(posedge clk); #1;

      $display("[TB] full write, byte-lane merges and strobe no-op");
      doWrite(BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111);
      doRead (BASE + 32'h10, 32'hDEAD_BEEF);
      doWrite(BASE + 32'h10, 32'h0000_AB00, 4'b0010);
      doRead (BASE + 32'h10, 32'hDEAD_ABEF);
      doWrite(BASE + 32'h10, 32'h1234_5678, 4'b0000);
      doRead (BASE + 32'h10, 32'hDEAD_ABEF);
      doWrite(BASE + 32'h10, 32'h11FF_FF22, 4'b1001);
      doRead (BASE + 32'h10, 32'h11AD_AB22);

      $display("[TB] error responses and range edges");
      doWrite(BASE, 32'hA5A5_A5A5, 4'b1111);
      doError(32'h7FFF_FFFC, 1'b0);
      doError(BASE + 32'h2, 1'b1);
      doError(BASE + 32'h1000, 1'b0);
      doRead (BASE, 32'hA5A5_A5A5);
      doWrite(BASE + 32'hFFC, 32'h0F0F_0F0F, 4'b1111);
      doRead (BASE + 32'hFFC, 32'h0F0F_0F0F);

      $display("[TB] back-to-back writes and reads");
      doWrite(BASE, 32'h0102_0304, 4'b1111);
      doWrite(BASE + 32'h4, 32'h0506_0708, 4'b1111);
      doRead (BASE, 32'h0102_0304);
      doRead (BASE + 32'h4, 32'h0506_0708);

      $display("[TB] reset during an in-flight write");
      doWrite(BASE + 32'h20, 32'h1122_3344, 4'b1111);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = BASE + 32'h20;
      pdata   = 32'hFFFF_FFFF;
      pstb    = 4'b1111;
      @(posedge clk); #1;
      penable = 1'b1;
      rts     = 1'b1;
      @(posedge clk); #1;
      rts     = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      checkOutput("abort_rst_pready", {31'b0, pready}, 32'h0);
      checkOutput("abort_rst_perr", {31'b0, perr}, 32'h0);
      checkOutput("abort_rst_prdata", prdata, 32'h0);
      @(posedge clk); #1;
      doRead(BASE + 32'h20, 32'h1122_3344);

      $display("[TB] psel dropped after setup");
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = BASE + 32'h20;
      pdata   = 32'hCAFE_F00D;
      pstb    = 4'b1111;
      @(posedge clk); #1;
      psel    = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("abort_psel_pready", {31'b0, pready}, 32'h0);
      @(posedge clk); #1;
      doRead(BASE + 32'h20, 32'h1122_3344);

      $display("[TB] bus changes during access phase are ignored");
      applyStimulus(BASE + 32'h8, 1'b1, 32'h5555_AAAA, 4'b1111, 32'h0, 1'b0, 1'b1);
      doRead(BASE + 32'h8, 32'h5555_AAAA);
      doRead(BASE, 32'h0102_0304);

      repeat (3) @(posedge clk);
      checkOutput("scoreboard_drained", expQ.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
